// File: rtl/inst_fetch.sv
// In-order instruction fetch: issues word fetches to instruction memory, buffers returned words for
// decode, and handles redirects. Defining INST_FETCH_PERF_CNT_EN adds the fetch_cnt output.
module inst_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [63:0] fetch_cnt
`endif
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = CW1'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'h3;
  endfunction

  logic [63:0]   fetch_pc;
  logic [63:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occ;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [63:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];

  logic          pop_raw;
  logic          pop;
  logic          discard;
  logic          keep;
  logic          xfer;
  logic [CW:0]   credit;

  assign inst_valid = (occ != '0);
  assign pop_raw    = inst_valid & inst_ready;
  assign pop        = pop_raw & ~redirect;
  assign discard    = imem_rvalid & (drop_cnt != '0);
  assign keep       = imem_rvalid & (drop_cnt == '0) & ~redirect;

  // A slot freed this cycle (pop or discarded response) can be reused immediately, which is what
  // lets a single-cycle memory stream one instruction per cycle through a two-entry buffer.
  assign credit   = {1'b0, outstanding} + {1'b0, occ}
                  - {{CW{1'b0}}, pop_raw} - {{CW{1'b0}}, discard};
  assign imem_req  = ~rst & ~redirect & (credit < DEPTH_C);
  assign xfer      = imem_req & imem_gnt;
  assign imem_addr = imem_req ? fetch_pc : '0;

  assign inst    = inst_valid ? inst_mem[rd_ptr] : '0;
  assign inst_pc = inst_valid ? pc_mem[rd_ptr]   : '0;

  // Responses are in order, so the pc of the next kept response is simply tracked alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      occ         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(xfer) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        drop_cnt <= outstanding - CW'(imem_rvalid);
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (xfer) fetch_pc <= fetch_pc + 64'd4;
        if (discard) drop_cnt <= drop_cnt - CW'(1);
        if (keep) begin
          rsp_pc <= rsp_pc + 64'd4;
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        occ <= occ + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef INST_FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if (pop) begin
      fetch_cnt <= fetch_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run checked against a transaction-level
// model built from the memory transfer log.
module tb_inst_fetch;
  localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, redirect;
  logic [63:0] imem_addr, inst_pc, redirect_pc;
  logic [31:0] imem_rdata, inst;
  logic        w_req, w_rvalid, w_valid;
  logic [63:0] w_addr, w_pc;
  logic [31:0] w_rdata, w_inst;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [63:0] fetch_cnt, w_fetch_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
`ifdef INST_FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt),
`endif
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  inst_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_w (
`ifdef INST_FETCH_PERF_CNT_EN
    .fetch_cnt(w_fetch_cnt),
`endif
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .inst_valid(w_valid), .inst(w_inst),
    .inst_pc(w_pc), .inst_ready(1'b1), .redirect(1'b0), .redirect_pc(64'd0)
  );

  // memory model state: transfer log in order, with the cycle each transfer was granted
  logic [63:0] mq_addr[$];
  int          mq_cyc[$];
  int          cyc = 0;
  bit          w_pending;
  logic [63:0] w_pend_addr;

  bit          o_req, o_xfer, o_valid, o_rv, o_wv;
  logic [63:0] o_addr, o_pc, o_rv_addr, o_wpc;
  logic [31:0] o_inst, o_winst;
  int          o_qb;

  function automatic logic [31:0] mk(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A3C_96E1;
  endfunction

  // entered and left at posedge+1; drives one cycle, samples at negedge
  task automatic step(input bit rdy, input bit gnt, input bit rv_en, input bit redir,
                      input logic [63:0] rpc);
    cyc++;
    inst_ready = rdy; imem_gnt = gnt; redirect = redir; redirect_pc = rpc;
    o_qb = mq_addr.size();
    if (rv_en && mq_addr.size() > 0 && mq_cyc[0] < cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mk(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    w_rvalid = w_pending; w_rdata = mk(w_pend_addr);
    @(negedge clk);
    o_req = imem_req; o_addr = imem_addr; o_xfer = imem_req & imem_gnt;
    o_valid = inst_valid; o_pc = inst_pc; o_inst = inst; o_rv = imem_rvalid; o_rv_addr = '0;
    o_wv = w_valid; o_wpc = w_pc; o_winst = w_inst;
    if (imem_rvalid) begin
      o_rv_addr = mq_addr.pop_front();
      mq_cyc.delete(0);
    end
    if (o_xfer) begin
      mq_addr.push_back(imem_addr);
      mq_cyc.push_back(cyc);
    end
    w_pending = w_req; w_pend_addr = w_addr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
    redirect = 0; redirect_pc = '0; w_rvalid = 0; w_rdata = '0;
    mq_addr.delete(); mq_cyc.delete(); w_pending = 0; w_pend_addr = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    total++; if (imem_addr !== 64'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", inst_valid); end
    total++; if (inst !== 32'd0) begin bad++; $display("FAIL rst_inst: got %h want 0", inst); end
    total++; if (inst_pc !== 64'd0) begin bad++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
    do_reset();
    step(1, 0, 0, 0, '0);
    total++; if (o_req !== 1'b1 || o_addr !== RST_PC) begin bad++; $display("FAIL first_req: got req=%0b addr=%h want 1 %h", o_req, o_addr, RST_PC); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0, '0);
      if (i < 2) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_lat%0d: got valid=%0b want 0", i, o_valid); end
      end else begin
        total++;
        if (o_valid !== 1'b1 || o_pc !== RST_PC + 64'(4 * (i - 2)) || o_inst !== mk(RST_PC + 64'(4 * (i - 2)))) begin
          bad++; $display("FAIL stream%0d: got v=%0b pc=%h inst=%h want pc=%h", i, o_valid, o_pc, o_inst, RST_PC + 64'(4 * (i - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    int late_req = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, '0);
      n += int'(o_xfer);
      if (i >= 2) late_req += int'(o_req);
    end
    total++; if (n != 2) begin bad++; $display("FAIL stall_xfers: got %0d want 2", n); end
    total++; if (late_req != 0) begin bad++; $display("FAIL stall_req: got %0d req cycles want 0", late_req); end
    total++; if (o_valid !== 1'b1 || o_pc !== RST_PC) begin bad++; $display("FAIL stall_head: got v=%0b pc=%h want 1 %h", o_valid, o_pc, RST_PC); end
    step(1, 1, 1, 0, '0);
    total++; if (o_req !== 1'b1) begin bad++; $display("FAIL stall_resume: got req=%0b want 1", o_req); end
  endtask

  task automatic test_gnt();
    int n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, '0);
      n += int'(o_xfer);
      total++; if (o_req !== 1'b1 || o_addr !== RST_PC) begin bad++; $display("FAIL gnt_hold%0d: got req=%0b addr=%h want 1 %h", i, o_req, o_addr, RST_PC); end
    end
    total++; if (n != 0) begin bad++; $display("FAIL gnt_noxfer: got %0d want 0", n); end
    step(1, 1, 1, 0, '0);
    total++; if (o_xfer !== 1'b1 || o_addr !== RST_PC) begin bad++; $display("FAIL gnt_xfer: got x=%0b addr=%h want 1 %h", o_xfer, o_addr, RST_PC); end
    step(1, 0, 0, 0, '0);
    total++; if (o_addr !== RST_PC + 64'd4) begin bad++; $display("FAIL gnt_next: got %h want %h", o_addr, RST_PC + 64'd4); end
  endtask

  task automatic test_redirect_latency();
    do_reset();
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 1, 64'h0000_0000_1234_5677);
    total++; if (o_req !== 1'b0) begin bad++; $display("FAIL redir_req_low: got %0b want 0", o_req); end
    step(1, 0, 0, 0, '0);
    total++; if (o_req !== 1'b1 || o_addr !== 64'h0000_0000_1234_5674) begin bad++; $display("FAIL redir_next: got req=%0b addr=%h want 1 12345674", o_req, o_addr); end
  endtask

  task automatic test_redirect();
    bit found = 0;
    logic [63:0] fpc = '0;
    logic [31:0] finst = '0;
    do_reset();
    step(1, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 1, 64'h0000_0000_8000_1000);
    step(1, 1, 1, 0, '0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_low: got %0b want 0", o_valid); end
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 1, 0, '0);
      if (o_valid) begin found = 1; fpc = o_pc; finst = o_inst; end
    end
    total++; if (!found) begin bad++; $display("FAIL redir_timeout: got no valid want valid within 20 cycles"); end
    total++; if (fpc !== 64'h0000_0000_8000_1000 || finst !== mk(64'h0000_0000_8000_1000)) begin bad++; $display("FAIL redir_first: got pc=%h inst=%h want 80001000", fpc, finst); end
  endtask

  task automatic test_wrap();
    logic [63:0] wq[$];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 0, '0);
      if (o_wv) begin
        wq.push_back(o_wpc);
        total++; if (o_winst !== mk(o_wpc)) begin bad++; $display("FAIL wrap_inst: got %h want %h", o_winst, mk(o_wpc)); end
      end
    end
    total++; if (wq.size() < 3) begin bad++; $display("FAIL wrap_count: got %0d want >=3", wq.size()); end
    else begin
      total++; if (wq[0] !== WRAP_PC) begin bad++; $display("FAIL wrap_pc0: got %h want %h", wq[0], WRAP_PC); end
      total++; if (wq[1] !== 64'd0) begin bad++; $display("FAIL wrap_pc1: got %h want 0", wq[1]); end
      total++; if (wq[2] !== 64'd4) begin bad++; $display("FAIL wrap_pc2: got %h want 4", wq[2]); end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL mid_full: got valid=%0b want 1", o_valid); end
    rst = 1'b1; #1;
    total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL mid_async: got req=%0b valid=%0b want 0 0", imem_req, inst_valid); end
    total++; if (imem_addr !== 64'd0 || inst_pc !== 64'd0) begin bad++; $display("FAIL mid_zero: got addr=%h pc=%h want 0 0", imem_addr, inst_pc); end
    do_reset();
    step(1, 1, 1, 0, '0);
    total++; if (o_req !== 1'b1 || o_addr !== RST_PC) begin bad++; $display("FAIL mid_restart: got req=%0b addr=%h want 1 %h", o_req, o_addr, RST_PC); end
    for (int i = 0; i < 4 && !found; i++) begin
      step(1, 1, 1, 0, '0);
      if (o_valid) begin
        found = 1;
        total++; if (o_pc !== RST_PC) begin bad++; $display("FAIL mid_first_pc: got %h want %h", o_pc, RST_PC); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_timeout: got no valid want valid within 4 cycles"); end
  endtask

  task automatic test_random();
    logic [63:0] m_fetch = RST_PC;
    logic [63:0] m_fifo[$];
    int m_drop = 0;
    int delivered = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit rdy, gnt, rv, redir;
      logic [63:0] rpc;
      rdy = ($urandom % 100) < 70;
      gnt = ($urandom % 100) < 75;
      rv = ($urandom % 100) < 60;
      redir = ($urandom % 100) < 3;
      rpc = (($urandom % 4) == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FFF0 | ($urandom % 16)} : {$urandom, $urandom};
      step(rdy, gnt, rv, redir, rpc);
      if (redir) begin
        total++; if (o_req !== 1'b0) begin bad++; $display("FAIL rnd_redir_req: cyc %0d got %0b want 0", cyc, o_req); end
      end
      if (o_xfer) begin
        total++; if (o_addr !== m_fetch) begin bad++; $display("FAIL rnd_addr: cyc %0d got %h want %h", cyc, o_addr, m_fetch); end
        m_fetch = m_fetch + 64'd4;
      end
      total++; if (o_valid !== (m_fifo.size() != 0)) begin bad++; $display("FAIL rnd_valid: cyc %0d got %0b want %0b", cyc, o_valid, m_fifo.size() != 0); end
      if (m_fifo.size() != 0) begin
        total++; if (o_pc !== m_fifo[0] || o_inst !== mk(m_fifo[0])) begin bad++; $display("FAIL rnd_head: cyc %0d got pc=%h inst=%h want %h %h", cyc, o_pc, o_inst, m_fifo[0], mk(m_fifo[0])); end
      end else begin
        total++; if (o_pc !== 64'd0 || o_inst !== 32'd0) begin bad++; $display("FAIL rnd_idle: cyc %0d got pc=%h inst=%h want 0 0", cyc, o_pc, o_inst); end
      end
      if (redir) begin
        m_fifo.delete();
        m_drop = o_qb - int'(o_rv);
        m_fetch = rpc & ~64'h3;
      end else begin
        if (rdy && m_fifo.size() != 0) begin
          void'(m_fifo.pop_front());
          delivered++;
        end
        if (o_rv) begin
          if (m_drop > 0) m_drop--;
          else m_fifo.push_back(o_rv_addr);
        end
      end
      total++; if (mq_addr.size() + m_fifo.size() > DEPTH) begin bad++; $display("FAIL rnd_capacity: cyc %0d got %0d want <=%0d", cyc, mq_addr.size() + m_fifo.size(), DEPTH); end
    end
    total++; if (delivered < 100) begin bad++; $display("FAIL rnd_progress: got %0d delivered want >=100", delivered); end
  endtask

  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ready = 0; redirect = 0;
    redirect_pc = '0; w_rvalid = 0; w_rdata = '0; w_pending = 0; w_pend_addr = '0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_gnt();
    test_redirect_latency();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (legal 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  64  fetch address, word aligned.
REQ-007 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data returned this cycle.
REQ-009 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-010 SHALL have port inst_valid  output  1  buffer head holds an instruction for decode.
REQ-011 SHALL have port inst  output  32  instruction word at buffer head.
REQ-012 SHALL have port inst_pc  output  64  address of inst.
REQ-013 SHALL have port inst_ready  input  1  decode consumes head this cycle.
REQ-014 SHALL have port redirect  input  1  flush and restart fetch (branch/jump).
REQ-015 SHALL have port redirect_pc  input  64  restart address.

Function
REQ-016 Memory handshake: request transfers when imem_req & imem_gnt; imem_req/imem_addr held stable until granted unless redirect.
REQ-017 Memory returns exactly one imem_rvalid per transfer, in order, no earlier than the cycle after grant.
REQ-018 Outstanding counter: +1 per transfer, -1 per imem_rvalid, both in same cycle = unchanged.
REQ-019 imem_req asserted only when outstanding + FIFO occupancy < FIFO_DEPTH and no redirect this cycle; buffer never overflows.
REQ-020 Fetch PC advances by 4 on each transfer; wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-021 Non-discarded imem_rvalid pushes {pc, imem_rdata} into FIFO tail; pc is the address of the matching transfer.
REQ-022 inst_valid = FIFO non-empty; inst/inst_pc = head entry, forced to 0 when inst_valid=0.
REQ-023 Pop when inst_valid & inst_ready; push and pop in same cycle legal, occupancy unchanged.
REQ-024 Redirect (priority over push/pop/issue): FIFO emptied, fetch PC <= redirect_pc, drop counter <= outstanding minus any response arriving that cycle, imem_req low that cycle.
REQ-025 While drop counter > 0, each imem_rvalid decrements it and is discarded; new requests may still issue.
REQ-026 Redirect while drop counter > 0 accumulates: new drop count = total outstanding.
REQ-027 Fetch latency: redirect in cycle N -> imem_req with redirect_pc in cycle N+1.
REQ-028 redirect_pc[1:0] ignored (treated as 0).

Reset
REQ-029 On rst high, immediately: imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, FIFO empty, outstanding=0, drop=0, fetch PC=RESET_PC.
REQ-030 First imem_req with imem_addr=RESET_PC in first cycle after rst deasserts.
REQ-031 Responses for transfers made before a reset are not generated by memory; no drop tracking across reset.

Configuration
REQ-032 Macro INST_FETCH_PERF_CNT_EN defined: output fetch_cnt (64) counts instructions popped to decode, reset 0, wraps; retained across redirect.
REQ-033 Macro undefined: fetch_cnt port and counter absent; all other behaviour identical.

Verification
REQ-034 Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> inst_pc sequence 0x80000000, 0x80000004, 0x80000008, one per cycle after initial 2-cycle latency.
REQ-035 ready=0 for 10 cycles -> exactly 2 transfers, inst_valid=1 holding pc 0x80000000, imem_req low until a pop.
REQ-036 gnt low 3 cycles -> imem_addr stable 0x80000000 throughout, single transfer on grant.
REQ-037 Redirect to 0x80001000 with 2 outstanding -> next 2 rvalids discarded, first inst_pc presented = 0x80001000, inst_valid low the cycle after redirect.
REQ-038 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second inst_pc = 0.
REQ-039 rst asserted mid-stream with FIFO full -> inst_valid and imem_req 0 without clock edge; restart at RESET_PC.
